// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared defaults and helpers for the ROM arbiter.
//   DEF_NREQ / DEF_AW / DEF_DW : default requester count, ROM address and data widths
//   ROM_RD_LAT                 : ROM read latency in cycles (address at rise, data by next rise)
//   onehot_to_index()          : index of the set bit in a one-hot vector of up to 8 bits
package rom_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 5;
  localparam int ROM_RD_LAT = 1;

  // OR-reduction form: cheap for a true one-hot input, which is all the arbiter ever passes.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester-side bus of the ROM arbiter.
//   req    : per-requester request level          (requesters -> arbiter)
//   addr   : packed per-requester addresses        (requesters -> arbiter)
//   gnt    : one-hot grant, address issued to ROM  (arbiter -> requesters)
//   rvalid : one-hot read-data owner               (arbiter -> requesters)
//   rdata  : shared read data                      (arbiter -> requesters)
// Modports: master = requester side, slave = arbiter side.
import rom_arb_pkg::*;

interface rom_arbiter_if #(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   elig    : eligible request vector
//   ptr     : index where the search starts (rotates upward, wraps NREQ-1 -> 0)
//   win_oh  : one-hot winner (zero when nothing is eligible)
//   win_idx : binary index of the winner
//   any     : at least one eligible request
import rom_arb_pkg::*;

module rr_pick #(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    win_oh = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // one extra bit so ptr + k never overflows before the wrap
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      idx = sum[IW-1:0];
      if (elig[idx] && (win_oh == '0)) win_oh[idx] = 1'b1;
    end
  end

  assign any     = |elig;
  assign win_idx = IW'(onehot_to_index(8'(win_oh)));

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port ROM (falling-edge read) among NREQ requesters.
// One grant per cycle; read data returns to the winner one cycle after its grant.
//   clk      : system clock, state updates on the rising edge
//   rst      : synchronous active-high reset
//   bus      : requester bus (req/addr in, gnt/rvalid/rdata out), slave modport
//   rom_addr : registered ROM address
//   rom_data : ROM read data, valid from the falling edge after rom_addr changes
// Build option: define ROM_ARB_FIXED_PRI_EN for fixed priority (lowest index wins,
// no pointer register); default is round-robin.
import rom_arb_pkg::*;

module rom_arbiter #(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_oh;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic [IW-1:0]   ptr;

  // A requester granted this cycle sits out the next decision, giving it
  // a cycle to drop req or present its next address.
  assign elig = bus.req & ~bus.gnt;

`ifdef ROM_ARB_FIXED_PRI_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
    end
  end
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .elig    (elig),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // Stage 1: grant and ROM address. Stage 2: capture ROM word for last cycle's winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.gnt    <= '0;
      bus.rvalid <= '0;
      bus.rdata  <= '0;
      rom_addr   <= '0;
    end else begin
      bus.gnt <= win_oh;
      if (win_any) rom_addr <= bus.addr[int'(win_idx)*AW +: AW];
      bus.rvalid <= bus.gnt;
      if (|bus.gnt) bus.rdata <= rom_data;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] rom_addr;
  logic [4:0] rom_data;
  int         checks;
  int         errors;

  rom_arbiter_if #(.NREQ(4), .AW(5), .DW(5)) bus ();

  rom_arbiter #(.NREQ(4), .AW(5), .DW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word(a) = (7a + 3) mod 32 -> 0:3 1:10 2:17 3:24 4:31 5:6 6:13 7:20
  function automatic logic [4:0] rom_word(input logic [4:0] a);
    return 5'((int'(a) * 7 + 3) % 32);
  endfunction

  initial rom_data = '0;
  always @(negedge clk) rom_data <= rom_word(rom_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.addr = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt c%0d: got %b want 0000", c, bus.gnt); end
      checks++;
      if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid c%0d: got %b want 0000", c, bus.rvalid); end
      checks++;
      if (bus.rdata !== 5'd0) begin errors++; $display("FAIL reset_rdata c%0d: got %0d want 0", c, bus.rdata); end
      checks++;
      if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_rom_addr c%0d: got %0d want 0", c, rom_addr); end
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); end
    checks++;
    if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL reset_first_rvalid: got %b want 0000", bus.rvalid); end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_single();
    do_reset();
    bus.req  = 4'b0100;
    bus.addr = {5'd0, 5'd3, 5'd0, 5'd0};
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt_k: got %b want 0100", bus.gnt); end
    checks++;
    if (rom_addr !== 5'd3) begin errors++; $display("FAIL single_rom_addr: got %0d want 3", rom_addr); end
    step();
    checks++;
    if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_k1: got %b want 0000", bus.gnt); end
    checks++;
    if (bus.rvalid !== 4'b0100) begin errors++; $display("FAIL single_rvalid: got %b want 0100", bus.rvalid); end
    checks++;
    if (bus.rdata !== 5'd24) begin errors++; $display("FAIL single_rdata: got %0d want 24", bus.rdata); end
    step();
    checks++;
    if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt_k2: got %b want 0100", bus.gnt); end
    checks++;
    if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL single_rvalid_k2: got %b want 0000", bus.rvalid); end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_rotate();
    logic [3:0] eg [6];
    logic [3:0] ev [6];
    logic [4:0] ed [6];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ev = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ed = '{5'd0, 5'd3, 5'd10, 5'd17, 5'd24, 5'd3};
    do_reset();
    bus.req  = 4'b1111;
    bus.addr = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (bus.gnt !== eg[c]) begin errors++; $display("FAIL rotate_gnt c%0d: got %b want %b", c, bus.gnt, eg[c]); end
      checks++;
      if (bus.rvalid !== ev[c]) begin errors++; $display("FAIL rotate_rvalid c%0d: got %b want %b", c, bus.rvalid, ev[c]); end
      checks++;
      if (bus.rdata !== ed[c]) begin errors++; $display("FAIL rotate_rdata c%0d: got %0d want %0d", c, bus.rdata, ed[c]); end
    end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req  = 4'b1000;
    bus.addr = {5'd5, 5'd0, 5'd0, 5'd7};
    step();
    checks++;
    if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3: got %b want 1000", bus.gnt); end
    bus.req = 4'b1001;
    step();
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", bus.gnt); end
    checks++;
    if (bus.rdata !== 5'd6) begin errors++; $display("FAIL wrap_rdata3: got %0d want 6", bus.rdata); end
    step();
    checks++;
    if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt3b: got %b want 1000", bus.gnt); end
    checks++;
    if (bus.rvalid !== 4'b0001) begin errors++; $display("FAIL wrap_rvalid0: got %b want 0001", bus.rvalid); end
    checks++;
    if (bus.rdata !== 5'd20) begin errors++; $display("FAIL wrap_rdata0: got %0d want 20", bus.rdata); end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req  = 4'b0011;
    bus.addr = {5'd0, 5'd0, 5'd2, 5'd1};
    step();
    step();
    checks++;
    if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt1: got %b want 0010", bus.gnt); end
    rst = 1'b1;
    step();
    checks++;
    if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_rst: got %b want 0000", bus.rvalid); end
    rst = 1'b0;
    step();
    checks++;
    if (bus.rvalid !== 4'b0000) begin errors++; $display("FAIL mid_rvalid_rel: got %b want 0000", bus.rvalid); end
    checks++;
    if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_restart_gnt: got %b want 0001", bus.gnt); end
    step();
    checks++;
    if (bus.rvalid !== 4'b0001) begin errors++; $display("FAIL mid_rvalid0: got %b want 0001", bus.rvalid); end
    checks++;
    if (bus.rdata !== 5'd10) begin errors++; $display("FAIL mid_rdata0: got %0d want 10", bus.rdata); end
    bus.req = '0;
    step();
    step();
  endtask

  task automatic test_fixed_pri();
    logic [3:0] eg [4];
    eg = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    do_reset();
    bus.req  = 4'b0110;
    bus.addr = {5'd0, 5'd6, 5'd4, 5'd0};
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.gnt !== eg[c]) begin errors++; $display("FAIL fixed_gnt c%0d: got %b want %b", c, bus.gnt, eg[c]); end
    end
    checks++;
    if (bus.rdata !== 5'd31) begin errors++; $display("FAIL fixed_rdata: got %0d want 31", bus.rdata); end
    bus.req = '0;
    step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    test_reset();
    test_single();
    test_reset_mid();
`ifdef ROM_ARB_FIXED_PRI_EN
    test_fixed_pri();
`else
    test_rotate();
    test_wrap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
